truth_table_sweeper: RTL and testbench

- Stimulus/capture stage wrapped around a combinational logic gate under test (GUT), such as a 3-input gate described as a truth-table case statement over {in3,in2,in1}.
- Upstream side: drives every input combination onto the GUT inputs in ascending order, waiting a programmable settle time for each.
- Downstream side: samples the GUT output for each combination and assembles the full truth table.
- Compares the assembled table against an expected table and reports pass/fail. This lets each synthesized gate be checked against its specification.

---
 rtl/truth_table_sweeper_if.sv | 27 ++
 rtl/truth_table_sweeper.sv | 112 +++++++++++
 tb/tb_truth_table_sweeper.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/truth_table_sweeper_if.sv
// Handshake and data bundle between the truth-table sweeper and its test driver / gate under test.
interface truth_table_sweeper_if #(
    parameter int unsigned N_IN = 3
) ();
    localparam int unsigned TT_W = 1 << N_IN;

    logic              start;
    logic [TT_W-1:0]   expected;
    logic              gate_out;
    logic [N_IN-1:0]   in_vec;
    logic              busy;
    logic              done;
    logic [TT_W-1:0]   tt;
    logic              pass;

    // Driver side: requests sweeps, supplies the reference table and the gate output.
    modport master (
        output start, expected, gate_out,
        input  in_vec, busy, done, tt, pass
    );

    // Sweeper side.
    modport slave (
        input  start, expected, gate_out,
        output in_vec, busy, done, tt, pass
    );
endinterface

// File: rtl/truth_table_sweeper.sv
// Walks every input combination of a combinational gate, captures its truth table
// and compares it against a reference table captured at start.
module truth_table_sweeper #(
    parameter int unsigned N_IN   = 3,
    parameter int unsigned SETTLE = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    truth_table_sweeper_if.slave  bus
);
    localparam int unsigned TT_W  = 1 << N_IN;
    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [N_IN-1:0]    idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [TT_W-1:0]    shadow_q, shadow_d;
    logic [TT_W-1:0]    exp_q, exp_d;
    logic [TT_W-1:0]    tt_q, tt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;

    // idx is cleared on leaving FINISH, so it doubles as the GUT input vector.
    assign bus.in_vec = idx_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.tt     = tt_q;
    assign bus.pass   = pass_q;

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            cnt_q    <= '0;
            shadow_q <= '0;
            exp_q    <= '0;
            tt_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            exp_q    <= exp_d;
            tt_q     <= tt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
        end
    end

    // Next-state and next-output logic; results are registered on entry to FINISH
    // so tt/pass are already valid in the done cycle.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        exp_d    = exp_q;
        tt_d     = tt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        pass_d   = pass_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    exp_d    = bus.expected;
                    shadow_d = '0;
                    idx_d    = '0;
                    cnt_d    = CNT_W'(SETTLE);
                    busy_d   = 1'b1;
                    state_d  = RUN;
                end
            end
            RUN: begin
                if (cnt_q != '0) begin
                    cnt_d = CNT_W'(cnt_q - 1'b1);
                end else begin
                    shadow_d[idx_q] = bus.gate_out;
                    if (idx_q == N_IN'(TT_W - 1)) begin
                        tt_d    = shadow_d;
                        pass_d  = (shadow_d == exp_q);
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = FINISH;
                    end else begin
                        idx_d = N_IN'(idx_q + 1'b1);
                        cnt_d = CNT_W'(SETTLE);
                    end
                end
            end
            FINISH: begin
                idx_d   = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_truth_table_sweeper.sv
// Randomized and directed bench for truth_table_sweeper: two instances (settle 2 and 0)
// driven by table-defined gates, checked against a cycle-level reference model.
module tb_truth_table_sweeper;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [7:0] gate_a = 8'h00;
    logic [7:0] gate_b = 8'h00;

    int checks = 0;
    int errors = 0;

    // Reference model state: last reported table and pass flag per instance.
    logic [7:0] model_tt [2];
    logic       model_pass [2];

    truth_table_sweeper_if #(.N_IN(3)) bus_a ();
    truth_table_sweeper_if #(.N_IN(3)) bus_b ();

    // Gates under test, defined by their truth tables.
    assign bus_a.gate_out = gate_a[bus_a.in_vec];
    assign bus_b.gate_out = gate_b[bus_b.in_vec];

    truth_table_sweeper #(.N_IN(3), .SETTLE(2)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    truth_table_sweeper #(.N_IN(3), .SETTLE(0)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    // 0 in_vec, 1 busy, 2 done, 3 tt, 4 pass
    function automatic logic [31:0] obs(input int d, input int what);
        case (what)
            0: return d == 0 ? 32'(bus_a.in_vec) : 32'(bus_b.in_vec);
            1: return d == 0 ? 32'(bus_a.busy)   : 32'(bus_b.busy);
            2: return d == 0 ? 32'(bus_a.done)   : 32'(bus_b.done);
            3: return d == 0 ? 32'(bus_a.tt)     : 32'(bus_b.tt);
            default: return d == 0 ? 32'(bus_a.pass) : 32'(bus_b.pass);
        endcase
    endfunction

    task automatic set_start(input int d, input logic v);
        if (d == 0) bus_a.start = v; else bus_b.start = v;
    endtask

    task automatic set_exp(input int d, input logic [7:0] v);
        if (d == 0) bus_a.expected = v; else bus_b.expected = v;
    endtask

    task automatic set_gate(input int d, input logic [7:0] v);
        if (d == 0) gate_a = v; else gate_b = v;
    endtask

    // One full sweep on instance d, checked every cycle against the model.
    task automatic sweep(input int d, input logic [7:0] gate, input logic [7:0] exp_tbl, input bit mid_pulse);
        int s = (d == 0) ? 2 : 0;
        int done_cyc = 8 * (s + 1) + 1;
        string p;
        set_gate(d, gate);
        set_exp(d, exp_tbl);
        @(negedge clk);
        set_start(d, 1'b1);
        @(posedge clk);
        #1;
        set_start(d, 1'b0);
        set_exp(d, 8'($urandom));
        for (int n = 1; n <= done_cyc + 1; n++) begin
            @(negedge clk);
            p = $sformatf("d%0d s%0d n%0d", d, s, n);
            if (n < done_cyc) begin
                check({p, " in_vec"}, obs(d, 0), 32'((n - 1) / (s + 1)));
                check({p, " busy"},   obs(d, 1), 32'd1);
                check({p, " done"},   obs(d, 2), 32'd0);
                check({p, " tt_hold"}, obs(d, 3), 32'(model_tt[d]));
            end else if (n == done_cyc) begin
                check({p, " done"},   obs(d, 2), 32'd1);
                check({p, " busy"},   obs(d, 1), 32'd0);
                check({p, " in_vec"}, obs(d, 0), 32'd7);
                check({p, " tt"},     obs(d, 3), 32'(gate));
                check({p, " pass"},   obs(d, 4), 32'(gate == exp_tbl));
            end else begin
                check({p, " done_after"}, obs(d, 2), 32'd0);
                check({p, " busy_after"}, obs(d, 1), 32'd0);
                check({p, " in_vec_after"}, obs(d, 0), 32'd0);
                check({p, " tt_after"},   obs(d, 3), 32'(gate));
                check({p, " pass_after"}, obs(d, 4), 32'(gate == exp_tbl));
            end
            if (mid_pulse) set_start(d, logic'(n == done_cyc / 2));
        end
        set_start(d, 1'b0);
        model_tt[d]   = gate;
        model_pass[d] = (gate == exp_tbl);
    endtask

    initial begin
        bus_a.start = 1'b0; bus_a.expected = 8'h00;
        bus_b.start = 1'b0; bus_b.expected = 8'h00;
        model_tt[0] = 8'h00; model_tt[1] = 8'h00;
        model_pass[0] = 1'b0; model_pass[1] = 1'b0;

        // Reset state
        #2 rst = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            for (int w = 0; w < 5; w++) check($sformatf("reset d%0d w%0d", d, w), obs(d, w), 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;

        // Directed: gate true at 5 and 7, matching and mismatching reference
        sweep(0, 8'hA0, 8'hA0, 1'b0);

        // Asynchronous reset in the middle of idx 4
        gate_a = 8'hA0;
        @(negedge clk);
        bus_a.start = 1'b1;
        @(posedge clk);
        #1 bus_a.start = 1'b0;
        repeat (13) @(negedge clk);
        check("pre_reset in_vec", obs(0, 0), 32'd4);
        check("pre_reset pass", obs(0, 4), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("mid_reset in_vec", obs(0, 0), 32'd0);
        check("mid_reset busy",   obs(0, 1), 32'd0);
        check("mid_reset tt",     obs(0, 3), 32'd0);
        check("mid_reset pass",   obs(0, 4), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        model_tt[0] = 8'h00; model_tt[1] = 8'h00;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            check($sformatf("post_reset idle busy %0d", n), obs(0, 1), 32'd0);
            check($sformatf("post_reset idle in_vec %0d", n), obs(0, 0), 32'd0);
            check($sformatf("post_reset idle done %0d", n), obs(0, 2), 32'd0);
        end

        sweep(0, 8'hA0, 8'h80, 1'b0);
        // XOR of in1 and in2 with no settle cycles, with and without a stray start
        sweep(1, 8'h66, 8'h66, 1'b0);
        sweep(1, 8'h66, 8'h66, 1'b1);
        sweep(0, 8'hA0, 8'hA0, 1'b1);

        // start held across two sweeps of different gates
        gate_a = 8'h96;
        bus_a.expected = 8'h96;
        @(negedge clk);
        bus_a.start = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= 52; n++) begin
            @(negedge clk);
            if (n <= 24) begin
                check($sformatf("held n%0d in_vec", n), obs(0, 0), 32'((n - 1) / 3));
                check($sformatf("held n%0d tt", n), obs(0, 3), 32'(model_tt[0]));
            end else if (n == 25) begin
                check("held first done", obs(0, 2), 32'd1);
                check("held first tt",   obs(0, 3), 32'h96);
                check("held first pass", obs(0, 4), 32'd1);
                gate_a = 8'h3C;
                bus_a.expected = 8'hC3;
            end else if (n == 26) begin
                check("held gap busy", obs(0, 1), 32'd0);
                check("held gap in_vec", obs(0, 0), 32'd0);
                check("held gap done", obs(0, 2), 32'd0);
            end else if (n <= 50) begin
                check($sformatf("held n%0d busy", n), obs(0, 1), 32'd1);
                check($sformatf("held n%0d in_vec", n), obs(0, 0), 32'((n - 27) / 3));
                check($sformatf("held n%0d tt", n), obs(0, 3), 32'h96);
                check($sformatf("held n%0d done", n), obs(0, 2), 32'd0);
            end else if (n == 51) begin
                check("held second done", obs(0, 2), 32'd1);
                check("held second tt",   obs(0, 3), 32'h3C);
                check("held second pass", obs(0, 4), 32'd0);
                bus_a.start = 1'b0;
            end else begin
                check("held end busy", obs(0, 1), 32'd0);
                check("held end done", obs(0, 2), 32'd0);
            end
        end
        model_tt[0] = 8'h3C;

        // Randomized gates and references on both instances
        for (int i = 0; i < 8; i++) begin
            logic [7:0] g;
            logic [7:0] e;
            g = 8'($urandom);
            e = ($urandom_range(0, 1) == 1) ? g : 8'($urandom);
            sweep(i % 2, g, e, 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
